// File: rtl/serdes_noise_inject.sv
// serdes_noise_inject: channel-impairment block between SERDES tx and rx.
// Injects LFSR-driven sync-header and data-bit errors and keeps error statistics.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   in_data, in_hdr   block and sync header from the transmit side
//   cfg_enable        0 = registered pass-through, LFSR and stats frozen
//   cfg_mode          0 off, 1 random hdr, 2 random data bit, 3 hdr burst
//   cfg_threshold     event fires when lfsr <= threshold
//   cfg_burst_len     blocks per burst in mode 3 (0 behaves as 1)
//   cfg_block_limit   blocks to process before done (0 = unlimited)
//   cfg_seed_load     reload the LFSR with LFSR_SEED on the next edge
//   out_data, out_hdr block and header towards the receive side (1 cycle latency)
//   inject_hdr/data   flags for the block currently on out_*
//   stat_*            saturating block / header-error / data-error counters
//   done              block limit reached
module serdes_noise_inject #(
    parameter int          DATA_WIDTH  = 64,
    parameter logic [31:0] LFSR_SEED   = 32'h1234_5678,
    parameter int          CNT_WIDTH   = 32,
    parameter int          BURST_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [1:0]             in_hdr,
    input  logic                   cfg_enable,
    input  logic [1:0]             cfg_mode,
    input  logic [31:0]            cfg_threshold,
    input  logic [BURST_WIDTH-1:0] cfg_burst_len,
    input  logic [CNT_WIDTH-1:0]   cfg_block_limit,
    input  logic                   cfg_seed_load,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [1:0]             out_hdr,
    output logic                   inject_hdr,
    output logic                   inject_data,
    output logic [CNT_WIDTH-1:0]   stat_blocks,
    output logic [CNT_WIDTH-1:0]   stat_hdr_err,
    output logic [CNT_WIDTH-1:0]   stat_data_err,
    output logic                   done
);

    localparam int IDX_W = $clog2(DATA_WIDTH);
    // Taps of x^32+x^22+x^2+x+1 below bit 31; bit 31 comes from the rotate.
    localparam logic [31:0] LOW_TAPS = 32'h0020_0003;
    localparam logic [BURST_WIDTH-1:0] ONE_B = {{(BURST_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH:0] ONE_C = {{CNT_WIDTH{1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            lfsr_q, lfsr_d, lfsr_step;
    logic [BURST_WIDTH-1:0] rem_q, rem_d;
    logic                   active, ev, limit_hit;
    logic                   hdr_hit, bit_hit;
    logic [CNT_WIDTH:0]     blocks_inc;
    logic [IDX_W-1:0]       flip_idx;
    logic [DATA_WIDTH-1:0]  data_d;
    logic [1:0]             hdr_d;

    assign active     = cfg_enable && (state_q != DONE);
    assign ev         = cfg_enable && (lfsr_q <= cfg_threshold);
    assign blocks_inc = {1'b0, stat_blocks} + ONE_C;
    // Compare one bit wider so a saturated counter can never alias the limit.
    assign limit_hit  = (cfg_block_limit != '0) &&
                        (blocks_inc == {1'b0, cfg_block_limit});
    assign flip_idx   = lfsr_q[31 -: IDX_W];

    // Right-shifting Galois step: feedback bit rotates into bit 31.
    assign lfsr_step = {lfsr_q[0], lfsr_q[31:1]} ^ ({32{lfsr_q[0]}} & LOW_TAPS);

    always_comb begin
        lfsr_d = lfsr_q;
        if (cfg_seed_load)
            lfsr_d = LFSR_SEED;
        else if (active)
            lfsr_d = lfsr_step;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        if (!cfg_enable) begin
            if (state_q == DONE)
                state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cfg_mode == 2'd3 && ev && cfg_burst_len > ONE_B) begin
                        state_d = BURST;
                        rem_d   = cfg_burst_len - ONE_B;
                    end
                end
                BURST: begin
                    if (cfg_mode == 2'd3) begin
                        rem_d = rem_q - ONE_B;
                        if (rem_q == ONE_B)
                            state_d = IDLE;
                    end else begin
                        state_d = IDLE;
                    end
                end
                DONE: ;
                default: state_d = IDLE;
            endcase
            if (state_q != DONE && limit_hit)
                state_d = DONE;
        end
    end

    // Output decode: which corruption applies to the block being sampled.
    always_comb begin
        hdr_hit = 1'b0;
        bit_hit = 1'b0;
        if (cfg_enable) begin
            unique case (1'b1)
                (state_q == IDLE): begin
                    hdr_hit = ev && (cfg_mode == 2'd1 || cfg_mode == 2'd3);
                    bit_hit = ev && (cfg_mode == 2'd2);
                end
                (state_q == BURST): hdr_hit = (cfg_mode == 2'd3);
                default: ;
            endcase
        end
        data_d = in_data;
        if (bit_hit)
            data_d = in_data ^ ({{(DATA_WIDTH-1){1'b0}}, 1'b1} << flip_idx);
        // Corrupted header is 11 or 00, never a valid sync header.
        hdr_d = hdr_hit ? {2{~in_hdr[0]}} : in_hdr;
    end

    // State, LFSR, outputs and statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            lfsr_q        <= LFSR_SEED;
            rem_q         <= '0;
            out_data      <= '0;
            out_hdr       <= 2'b00;
            inject_hdr    <= 1'b0;
            inject_data   <= 1'b0;
            stat_blocks   <= '0;
            stat_hdr_err  <= '0;
            stat_data_err <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            rem_q       <= rem_d;
            out_data    <= data_d;
            out_hdr     <= hdr_d;
            inject_hdr  <= hdr_hit;
            inject_data <= bit_hit;
            if (active && stat_blocks != CNT_MAX)
                stat_blocks <= blocks_inc[CNT_WIDTH-1:0];
            if (hdr_hit && stat_hdr_err != CNT_MAX)
                stat_hdr_err <= stat_hdr_err + ONE_C[CNT_WIDTH-1:0];
            if (bit_hit && stat_data_err != CNT_MAX)
                stat_data_err <= stat_data_err + ONE_C[CNT_WIDTH-1:0];
        end
    end

    assign done = (state_q == DONE);

endmodule

// File: tb/tb_serdes_noise_inject.sv
// Testbench for serdes_noise_inject: directed vector table, hand sequences
// and randomized traffic checked against a block-level reference model.
module tb_serdes_noise_inject;

    localparam int          DW   = 64;
    localparam int          CW   = 8;
    localparam int          BW   = 16;
    localparam logic [31:0] SEED = 32'h1234_5678;
    localparam int          SAT  = (1 << CW) - 1;

    logic          clk_tb = 1'b0;
    logic          rx_rst_tb;
    logic [DW-1:0] in_data;
    logic [1:0]    in_hdr;
    logic          cfg_enable;
    logic [1:0]    cfg_mode;
    logic [31:0]   cfg_threshold;
    logic [BW-1:0] cfg_burst_len;
    logic [CW-1:0] cfg_block_limit;
    logic          cfg_seed_load;
    logic [DW-1:0] out_data;
    logic [1:0]    out_hdr;
    logic          inject_hdr;
    logic          inject_data;
    logic [CW-1:0] stat_blocks;
    logic [CW-1:0] stat_hdr_err;
    logic [CW-1:0] stat_data_err;
    logic          done;

    always #5 clk_tb = ~clk_tb;

    serdes_noise_inject #(
        .DATA_WIDTH(DW), .LFSR_SEED(SEED), .CNT_WIDTH(CW), .BURST_WIDTH(BW)
    ) dut (
        .clk(clk_tb), .rst(rx_rst_tb),
        .in_data(in_data), .in_hdr(in_hdr),
        .cfg_enable(cfg_enable), .cfg_mode(cfg_mode),
        .cfg_threshold(cfg_threshold), .cfg_burst_len(cfg_burst_len),
        .cfg_block_limit(cfg_block_limit), .cfg_seed_load(cfg_seed_load),
        .out_data(out_data), .out_hdr(out_hdr),
        .inject_hdr(inject_hdr), .inject_data(inject_data),
        .stat_blocks(stat_blocks), .stat_hdr_err(stat_hdr_err),
        .stat_data_err(stat_data_err), .done(done)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state: burst_left = header blocks still owed.
    logic [31:0] m_lfsr;
    int          m_blocks, m_herr, m_derr, m_burst;
    bit          m_done;
    logic [DW-1:0] e_data;
    logic [1:0]  e_hdr;
    bit          e_ih, e_id;

    // Multiply by x modulo p(x), bit-reversed Galois representation.
    function automatic logic [31:0] lfsr_next(logic [31:0] v);
        logic [31:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    function automatic int sat_inc(int v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    task automatic model_step();
        bit ev, hdr, adv;
        int flip;
        if (rx_rst_tb) begin
            m_lfsr = SEED; m_blocks = 0; m_herr = 0; m_derr = 0;
            m_burst = 0; m_done = 0;
            e_data = '0; e_hdr = 2'b00; e_ih = 0; e_id = 0;
            return;
        end
        ev   = cfg_enable && (m_lfsr <= cfg_threshold);
        hdr  = 0;
        flip = -1;
        adv  = cfg_enable && !m_done;
        if (adv) begin
            if (m_burst > 0) begin
                if (cfg_mode == 2'd3) begin
                    hdr = 1;
                    m_burst--;
                end else begin
                    m_burst = 0;
                end
            end else if (ev) begin
                case (cfg_mode)
                    2'd1: hdr = 1;
                    2'd2: flip = int'(m_lfsr >> 26);
                    2'd3: begin
                        hdr = 1;
                        m_burst = (cfg_burst_len == 0) ? 0 : int'(cfg_burst_len) - 1;
                    end
                    default: ;
                endcase
            end
        end
        e_data = in_data;
        if (flip >= 0) e_data = in_data ^ (64'd1 << flip);
        e_hdr = hdr ? {2{~in_hdr[0]}} : in_hdr;
        e_ih  = hdr;
        e_id  = (flip >= 0);
        if (hdr) m_herr = sat_inc(m_herr);
        if (e_id) m_derr = sat_inc(m_derr);
        if (adv) begin
            if (cfg_block_limit != 0 && m_blocks + 1 == int'(cfg_block_limit)) begin
                m_done  = 1;
                m_burst = 0;
            end
            m_blocks = sat_inc(m_blocks);
        end
        if (!cfg_enable) m_done = 0;
        if (cfg_seed_load) m_lfsr = SEED;
        else if (adv) m_lfsr = lfsr_next(m_lfsr);
    endtask

    task automatic chk(string name, longint unsigned got, longint unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One block: drive inputs, clock, compare every output with the model.
    task automatic cyc(logic [DW-1:0] d, logic [1:0] h);
        logic [92:0] got, exp;
        in_data = d;
        in_hdr  = h;
        @(posedge clk_tb);
        model_step();
        #1;
        got = {out_data, out_hdr, inject_hdr, inject_data,
               stat_blocks, stat_hdr_err, stat_data_err, done};
        exp = {e_data, e_hdr, e_ih, e_id, m_blocks[CW-1:0],
               m_herr[CW-1:0], m_derr[CW-1:0], m_done};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL cycle@%0t: got %h expected %h", $time, got, exp);
        end
    endtask

    task automatic set_cfg(bit en, logic [1:0] mode, logic [31:0] thr,
                           logic [BW-1:0] len, logic [CW-1:0] lim);
        cfg_enable = en; cfg_mode = mode; cfg_threshold = thr;
        cfg_burst_len = len; cfg_block_limit = lim;
    endtask

    task automatic do_reset();
        rx_rst_tb = 1;
        cyc('0, 2'b10);
        rx_rst_tb = 0;
    endtask

    typedef struct {
        bit          en;
        logic [1:0]  mode;
        logic [31:0] thr;
        logic [15:0] len;
        logic [7:0]  lim;
        int          n;
        int          dpat;
        int          e_blk, e_herr, e_derr;
        bit          e_done;
    } vec_t;

    localparam int NV = 8;
    vec_t tab [NV];
    bit   pat [7];
    bit   ref_seq [200];
    int   ref_herr, ref_blk;

    initial begin
        rx_rst_tb = 1; in_data = '0; in_hdr = 2'b10; cfg_seed_load = 0;
        set_cfg(0, 2'd0, 32'd0, 16'd0, 8'd0);

        tab[0] = '{1'b0, 2'd1, 32'hFFFF_FFFF, 16'd1, 8'd0,  20, 0,   0,   0,  0, 1'b0};
        tab[1] = '{1'b1, 2'd1, 32'h0,         16'd1, 8'd100,101,1, 100,   0,  0, 1'b1};
        tab[2] = '{1'b1, 2'd1, 32'hFFFF_FFFF, 16'd1, 8'd50, 60, 1,  50,  50,  0, 1'b1};
        tab[3] = '{1'b1, 2'd2, 32'hFFFF_FFFF, 16'd1, 8'd0,  30, 2,  30,   0, 30, 1'b0};
        tab[4] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 16'd4, 8'd0,  20, 1,  20,  20,  0, 1'b0};
        tab[5] = '{1'b1, 2'd1, 32'hFFFF_FFFF, 16'd1, 8'd0, 300, 1, 255, 255,  0, 1'b0};
        tab[6] = '{1'b1, 2'd0, 32'hFFFF_FFFF, 16'd1, 8'd10, 15, 1,  10,   0,  0, 1'b1};
        tab[7] = '{1'b1, 2'd2, 32'h0,         16'd1, 8'd0,  25, 1,  25,   0,  0, 1'b0};

        do_reset();
        chk("rst_out_data", out_data, 0);
        chk("rst_out_hdr", out_hdr, 0);
        chk("rst_done", done, 0);

        for (int v = 0; v < NV; v++) begin
            do_reset();
            set_cfg(tab[v].en, tab[v].mode, tab[v].thr, tab[v].len, tab[v].lim);
            for (int i = 0; i < tab[v].n; i++) begin
                logic [DW-1:0] d;
                logic [1:0] h;
                case (tab[v].dpat)
                    0: begin d = 64'd1 << (i % 64); h = 2'b10; end
                    1: begin d = {$urandom, $urandom}; h = (i % 2) ? 2'b01 : 2'b10; end
                    default: begin d = '0; h = 2'b01; end
                endcase
                cyc(d, h);
                if (tab[v].dpat == 2)
                    chk($sformatf("v%0d_onehot", v), $countones(out_data), 1);
            end
            chk($sformatf("v%0d_blocks", v), stat_blocks, tab[v].e_blk);
            chk($sformatf("v%0d_hdr_err", v), stat_hdr_err, tab[v].e_herr);
            chk($sformatf("v%0d_data_err", v), stat_data_err, tab[v].e_derr);
            chk($sformatf("v%0d_done", v), done, tab[v].e_done);
        end

        // Burst of 5 from a single event; later events are disabled.
        pat = '{1, 1, 1, 1, 1, 0, 0};
        do_reset();
        set_cfg(1, 2'd3, 32'hFFFF_FFFF, 16'd5, 8'd0);
        cyc({$urandom, $urandom}, 2'b10);
        chk("burst_0", inject_hdr, pat[0]);
        cfg_threshold = 32'h0;
        for (int i = 1; i < 7; i++) begin
            cyc({$urandom, $urandom}, 2'b01);
            chk($sformatf("burst_%0d", i), inject_hdr, pat[i]);
        end
        chk("burst_hdr_err", stat_hdr_err, 5);

        // Leaving mode 3 mid-burst stops corruption immediately.
        do_reset();
        set_cfg(1, 2'd3, 32'hFFFF_FFFF, 16'd8, 8'd0);
        cyc('0, 2'b10);
        cfg_threshold = 32'h0;
        cyc('0, 2'b10);
        cyc('0, 2'b10);
        cfg_mode = 2'd1;
        for (int i = 0; i < 3; i++) begin
            cyc('0, 2'b10);
            chk("mode_exit_clean", inject_hdr, 0);
        end
        chk("mode_exit_hdr_err", stat_hdr_err, 3);

        // Reset during a burst aborts it.
        do_reset();
        set_cfg(1, 2'd3, 32'hFFFF_FFFF, 16'd4, 8'd0);
        cyc('0, 2'b10);
        cyc('0, 2'b10);
        chk("rstburst_pre", stat_hdr_err, 2);
        rx_rst_tb = 1;
        cyc({$urandom, $urandom}, 2'b10);
        chk("rstburst_hdr", out_hdr, 0);
        chk("rstburst_stats", {stat_blocks, stat_hdr_err}, 0);
        rx_rst_tb = 0;
        cfg_threshold = 32'h0;
        for (int i = 0; i < 4; i++) begin
            cyc('0, 2'b10);
            chk("rstburst_after", inject_hdr, 0);
        end
        chk("rstburst_hdr_err", stat_hdr_err, 0);

        // Seed reload: two identical runs must be bit-exact.
        for (int r = 0; r < 2; r++) begin
            do_reset();
            set_cfg(0, 2'd1, 32'h6000_0000, 16'd1, 8'd0);
            cfg_seed_load = 1;
            cyc('0, 2'b10);
            cfg_seed_load = 0;
            cfg_enable = 1;
            for (int i = 0; i < 200; i++) begin
                cyc({$urandom, $urandom}, (i % 2) ? 2'b01 : 2'b10);
                if (r == 0) ref_seq[i] = e_ih;
                else chk("seed_seq", inject_hdr, ref_seq[i]);
            end
            if (r == 0) begin
                ref_herr = m_herr;
                ref_blk  = m_blocks;
            end else begin
                chk("seed_hdr_err", stat_hdr_err, ref_herr);
                chk("seed_blocks", stat_blocks, ref_blk);
            end
        end

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                logic [31:0] thr;
                case ($urandom_range(0, 3))
                    0: thr = 32'h0;
                    1: thr = 32'hFFFF_FFFF;
                    2: thr = $urandom;
                    default: thr = 32'h1000_0000;
                endcase
                set_cfg($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), thr,
                        16'($urandom_range(0, 6)),
                        ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 255)));
            end
            rx_rst_tb     = ($urandom_range(0, 199) == 0);
            cfg_seed_load = ($urandom_range(0, 99) == 0);
            cyc({$urandom, $urandom}, $urandom_range(0, 1) ? 2'b10 : 2'b01);
        end
        rx_rst_tb = 0;
        cfg_seed_load = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
